// File: rtl/loadstore_unit_pkg.sv
// Shared types and helpers for the load/store unit: memory access type
// encoding, FSM state encoding and per-size byte-enable masks.
package loadstore_unit_pkg;

  // Access size as delivered by the decoder; 2'b11 behaves as a word.
  typedef enum logic [1:0] {
    MEM_WORD     = 2'b00,
    MEM_BYTE     = 2'b01,
    MEM_HALF     = 2'b10,
    MEM_WORD_ALT = 2'b11
  } mem_type_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ0  = 3'd1,
    ST_WAIT0 = 3'd2,
    ST_REQ1  = 3'd3,
    ST_WAIT1 = 3'd4,
    ST_DONE  = 3'd5
  } lsu_state_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Right-justified byte mask covering the access size.
  function automatic logic [3:0] size_mask(input logic [1:0] mem_type);
    case (mem_type)
      MEM_BYTE: size_mask = BE_BYTE;
      MEM_HALF: size_mask = BE_HALF;
      default:  size_mask = BE_WORD;
    endcase
  endfunction

  // True when the access crosses into the next word (offset + size > 4).
  function automatic logic is_split(input logic [1:0] mem_type, input logic [1:0] offset);
    logic [7:0] wide;
    wide     = {4'b0000, size_mask(mem_type)} << offset;
    is_split = |wide[7:4];
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for the load/store unit: store byte-enables
// and data for both beats, and load extraction plus sign/zero extension.
module lsu_align
  import loadstore_unit_pkg::*;
(
  input  logic [1:0]  mem_type_i,
  input  logic [1:0]  offset_i,
  input  logic        sign_i,      // 0 sign-extend, 1 zero-extend
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_lo_i,  // beat-0 response word
  input  logic [31:0] rdata_hi_i,  // beat-1 response word
  output logic [3:0]  be0_o,
  output logic [3:0]  be1_o,
  output logic [31:0] wdata0_o,
  output logic [31:0] wdata1_o,
  output logic [31:0] rdata_o
);

  logic [4:0]  shamt;
  logic [7:0]  be_wide;
  logic [63:0] wd_wide;
  logic [31:0] rd_word;

  // Shifting a double-width value places beat 0 in the low half and the
  // spill-over for beat 1 in the high half with a single shifter.
  assign shamt    = {offset_i, 3'b000};
  assign be_wide  = {4'b0000, size_mask(mem_type_i)} << offset_i;
  assign wd_wide  = {32'h0000_0000, wdata_i} << shamt;
  assign rd_word  = 32'({rdata_hi_i, rdata_lo_i} >> shamt);

  assign be0_o    = be_wide[3:0];
  assign be1_o    = be_wide[7:4];
  assign wdata0_o = wd_wide[31:0];
  assign wdata1_o = wd_wide[63:32];

  // Truncate the realigned word to the access size and extend it.
  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    rdata_o = rd_word;
    case (mem_type_i)
      MEM_BYTE: rdata_o = {{24{~sign_i & rd_word[7]}}, rd_word[7:0]};
      MEM_HALF: rdata_o = {{16{~sign_i & rd_word[15]}}, rd_word[15:0]};
      default:  rdata_o = rd_word;
    endcase
  end

endmodule

// File: rtl/loadstore_unit.sv
// Multi-cycle load/store unit: turns byte/half/word accesses into
// word-aligned bus beats with byte enables and stalls the core meanwhile.
// Build option: MISALIGNED_SPLIT_EN performs word-crossing accesses as two
// beats; without it they are rejected and flagged on Misaligned_o.
module loadstore_unit
  import loadstore_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  Req_i,
  input  logic                  MemWrite_i,
  input  logic [1:0]            MemType_i,
  input  logic                  MemSign_i,
  input  logic [ADDR_WIDTH-1:0] Addr_i,
  input  logic [DATA_WIDTH-1:0] WriteData_i,
  output logic [DATA_WIDTH-1:0] ReadData_o,
  output logic                  Done_o,
  output logic                  Busy_o,
  output logic                  Misaligned_o,
  output logic                  BusReq_o,
  input  logic                  BusGnt_i,
  output logic [ADDR_WIDTH-1:0] BusAddr_o,
  output logic                  BusWe_o,
  output logic [3:0]            BusBe_o,
  output logic [DATA_WIDTH-1:0] BusWData_o,
  input  logic                  BusRValid_i,
  input  logic [DATA_WIDTH-1:0] BusRData_i
);

  lsu_state_e            state_q, state_d;
  logic                  write_q, write_d;
  logic [1:0]            type_q, type_d;
  logic                  sign_q, sign_d;
  logic [ADDR_WIDTH-3:0] word_q, word_d;
  logic [1:0]            off_q, off_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  split_q, split_d;
  logic [DATA_WIDTH-1:0] rlo_q, rlo_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
`ifndef MISALIGNED_SPLIT_EN
  logic                  mis_q, mis_d;
`endif

  logic [3:0]            be0, be1;
  logic [DATA_WIDTH-1:0] wdata0, wdata1, load_data, rd_lo;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic                  bus_active, in_beat1;

  // In WAIT0 the low word arrives this cycle; later it comes from rlo_q.
  assign rd_lo = (state_q == ST_WAIT0) ? BusRData_i : rlo_q;

  lsu_align u_align (
    .mem_type_i (type_q),
    .offset_i   (off_q),
    .sign_i     (sign_q),
    .wdata_i    (wdata_q),
    .rdata_lo_i (rd_lo),
    .rdata_hi_i (BusRData_i),
    .be0_o      (be0),
    .be1_o      (be1),
    .wdata0_o   (wdata0),
    .wdata1_o   (wdata1),
    .rdata_o    (load_data)
  );

  // Next-state and operand-capture logic for the access sequencer.
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    type_d  = type_q;
    sign_d  = sign_q;
    word_d  = word_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    split_d = split_q;
    rlo_d   = rlo_q;
    rdata_d = rdata_q;
`ifndef MISALIGNED_SPLIT_EN
    mis_d   = mis_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (Req_i) begin
          write_d = MemWrite_i;
          type_d  = MemType_i;
          sign_d  = MemSign_i;
          word_d  = Addr_i[ADDR_WIDTH-1:2];
          off_d   = Addr_i[1:0];
          wdata_d = WriteData_i;
          split_d = is_split(MemType_i, Addr_i[1:0]);
`ifdef MISALIGNED_SPLIT_EN
          state_d = ST_REQ0;
`else
          mis_d   = split_d;
          if (split_d) begin
            state_d = ST_DONE;
            if (!MemWrite_i) rdata_d = '0;
          end else begin
            state_d = ST_REQ0;
          end
`endif
        end
      end
      ST_REQ0: begin
        if (BusGnt_i) begin
          if (write_q) state_d = split_q ? ST_REQ1 : ST_DONE;
          else         state_d = ST_WAIT0;
        end
      end
      ST_WAIT0: begin
        if (BusRValid_i) begin
          rlo_d = BusRData_i;
          if (split_q) begin
            state_d = ST_REQ1;
          end else begin
            state_d = ST_DONE;
            rdata_d = load_data;
          end
        end
      end
      ST_REQ1: begin
        if (BusGnt_i) state_d = write_q ? ST_DONE : ST_WAIT1;
      end
      ST_WAIT1: begin
        if (BusRValid_i) begin
          state_d = ST_DONE;
          rdata_d = load_data;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and operand registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments let every register sample the pre-edge values.
    if (rst_i) begin
      state_q <= ST_IDLE;
      write_q <= 1'b0;
      type_q  <= 2'b00;
      sign_q  <= 1'b0;
      word_q  <= '0;
      off_q   <= 2'b00;
      wdata_q <= '0;
      split_q <= 1'b0;
      rlo_q   <= '0;
      rdata_q <= '0;
`ifndef MISALIGNED_SPLIT_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      type_q  <= type_d;
      sign_q  <= sign_d;
      word_q  <= word_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      split_q <= split_d;
      rlo_q   <= rlo_d;
      rdata_q <= rdata_d;
`ifndef MISALIGNED_SPLIT_EN
      mis_q   <= mis_d;
`endif
    end
  end

  // Bus fields are driven only during request states and are 0 otherwise.
  assign bus_active = (state_q == ST_REQ0) || (state_q == ST_REQ1);
  assign in_beat1   = (state_q == ST_REQ1);
  assign base_addr  = {word_q, 2'b00};

  assign BusReq_o   = bus_active;
  assign BusWe_o    = bus_active & write_q;
  assign BusAddr_o  = bus_active ? (in_beat1 ? base_addr + ADDR_WIDTH'(4) : base_addr) : '0;
  assign BusBe_o    = bus_active ? (in_beat1 ? be1 : be0) : 4'b0000;
  assign BusWData_o = bus_active ? (in_beat1 ? wdata1 : wdata0) : '0;

  assign Done_o     = (state_q == ST_DONE);
  assign ReadData_o = rdata_q;
  assign Busy_o     = (state_q inside {ST_REQ0, ST_WAIT0, ST_REQ1, ST_WAIT1}) ||
                      ((state_q == ST_IDLE) && Req_i);
`ifdef MISALIGNED_SPLIT_EN
  assign Misaligned_o = 1'b0;
`else
  assign Misaligned_o = Done_o & mis_q;
`endif

endmodule

// File: tb/tb_loadstore_unit.sv
// Directed testbench for loadstore_unit. Inputs are driven and outputs
// sampled on the falling clock edge; cycle 0 is the cycle Req_i is seen.
module tb_loadstore_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        Req_i = 1'b0;
  logic        MemWrite_i = 1'b0;
  logic [1:0]  MemType_i = 2'b00;
  logic        MemSign_i = 1'b0;
  logic [31:0] Addr_i = '0;
  logic [31:0] WriteData_i = '0;
  logic [31:0] ReadData_o;
  logic        Done_o, Busy_o, Misaligned_o, BusReq_o, BusWe_o;
  logic        BusGnt_i = 1'b0;
  logic [31:0] BusAddr_o, BusWData_o;
  logic [3:0]  BusBe_o;
  logic        BusRValid_i = 1'b0;
  logic [31:0] BusRData_i = '0;

  int checks = 0;
  int errors = 0;

  loadstore_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .Req_i        (Req_i),
    .MemWrite_i   (MemWrite_i),
    .MemType_i    (MemType_i),
    .MemSign_i    (MemSign_i),
    .Addr_i       (Addr_i),
    .WriteData_i  (WriteData_i),
    .ReadData_o   (ReadData_o),
    .Done_o       (Done_o),
    .Busy_o       (Busy_o),
    .Misaligned_o (Misaligned_o),
    .BusReq_o     (BusReq_o),
    .BusGnt_i     (BusGnt_i),
    .BusAddr_o    (BusAddr_o),
    .BusWe_o      (BusWe_o),
    .BusBe_o      (BusBe_o),
    .BusWData_o   (BusWData_o),
    .BusRValid_i  (BusRValid_i),
    .BusRData_i   (BusRData_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1);
  end

  task automatic set_req(input logic we, input logic [1:0] mt, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
    Req_i = 1'b1; MemWrite_i = we; MemType_i = mt; MemSign_i = sg;
    Addr_i = a; WriteData_i = wd;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    checks++; if (ReadData_o !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", ReadData_o); end
    checks++; if (Done_o !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", Done_o); end
    checks++; if (Busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", Busy_o); end
    checks++; if (Misaligned_o !== 1'b0) begin errors++; $display("FAIL rst_mis: got %b want 0", Misaligned_o); end
    checks++; if (BusReq_o !== 1'b0) begin errors++; $display("FAIL rst_busreq: got %b want 0", BusReq_o); end
    checks++; if (BusAddr_o !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", BusAddr_o); end
    checks++; if (BusWe_o !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", BusWe_o); end
    checks++; if (BusBe_o !== 4'h0) begin errors++; $display("FAIL rst_be: got %b want 0", BusBe_o); end
    checks++; if (BusWData_o !== 32'h0) begin errors++; $display("FAIL rst_wdata: got %h want 0", BusWData_o); end
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_store_byte;
    set_req(1'b1, 2'b01, 1'b0, 32'h0000_1003, 32'h0000_00A5);
    #1;
    checks++; if (Busy_o !== 1'b1) begin errors++; $display("FAIL sb_busy_c0: got %b want 1", Busy_o); end
    @(negedge clk_i);  // cycle 1
    checks++; if (BusReq_o !== 1'b1) begin errors++; $display("FAIL sb_busreq: got %b want 1", BusReq_o); end
    checks++; if (BusAddr_o !== 32'h0000_1000) begin errors++; $display("FAIL sb_addr: got %h want 00001000", BusAddr_o); end
    checks++; if (BusBe_o !== 4'b1000) begin errors++; $display("FAIL sb_be: got %b want 1000", BusBe_o); end
    checks++; if (BusWData_o !== 32'hA500_0000) begin errors++; $display("FAIL sb_wdata: got %h want a5000000", BusWData_o); end
    checks++; if (BusWe_o !== 1'b1) begin errors++; $display("FAIL sb_we: got %b want 1", BusWe_o); end
    Req_i = 1'b0; BusGnt_i = 1'b1;
    @(negedge clk_i);  // cycle 2
    BusGnt_i = 1'b0;
    checks++; if (Done_o !== 1'b1) begin errors++; $display("FAIL sb_done_c2: got %b want 1", Done_o); end
    checks++; if (Busy_o !== 1'b0) begin errors++; $display("FAIL sb_busy_done: got %b want 0", Busy_o); end
    checks++; if (BusReq_o !== 1'b0) begin errors++; $display("FAIL sb_busreq_done: got %b want 0", BusReq_o); end
    checks++; if (ReadData_o !== 32'h0) begin errors++; $display("FAIL sb_rdata_kept: got %h want 0", ReadData_o); end
    @(negedge clk_i);
    checks++; if (Done_o !== 1'b0) begin errors++; $display("FAIL sb_done_pulse: got %b want 0", Done_o); end
  endtask

  task automatic test_load_byte(input logic sg, input logic [31:0] exp);
    set_req(1'b0, 2'b01, sg, 32'h0000_2001, 32'h0);
    @(negedge clk_i);  // cycle 1
    checks++; if (BusAddr_o !== 32'h0000_2000) begin errors++; $display("FAIL lb_addr: got %h want 00002000", BusAddr_o); end
    checks++; if (BusBe_o !== 4'b0010) begin errors++; $display("FAIL lb_be: got %b want 0010", BusBe_o); end
    checks++; if (BusWe_o !== 1'b0) begin errors++; $display("FAIL lb_we: got %b want 0", BusWe_o); end
    Req_i = 1'b0; BusGnt_i = 1'b1;
    @(negedge clk_i);  // cycle 2, waiting for data
    BusGnt_i = 1'b0;
    checks++; if (BusReq_o !== 1'b0 || Busy_o !== 1'b1) begin errors++; $display("FAIL lb_wait: got req %b busy %b want 0 1", BusReq_o, Busy_o); end
    @(negedge clk_i);  // cycle 3, response arrives
    checks++; if (Done_o !== 1'b0) begin errors++; $display("FAIL lb_early_done: got %b want 0", Done_o); end
    BusRValid_i = 1'b1; BusRData_i = 32'h0000_8000;
    @(negedge clk_i);  // cycle 4
    BusRValid_i = 1'b0; BusRData_i = 32'h0;
    checks++; if (Done_o !== 1'b1) begin errors++; $display("FAIL lb_done: got %b want 1", Done_o); end
    checks++; if (ReadData_o !== exp) begin errors++; $display("FAIL lb_rdata sign=%b: got %h want %h", sg, ReadData_o, exp); end
    @(negedge clk_i);
    checks++; if (ReadData_o !== exp) begin errors++; $display("FAIL lb_rdata_hold: got %h want %h", ReadData_o, exp); end
  endtask

  task automatic test_store_half_stall;
    set_req(1'b1, 2'b10, 1'b0, 32'h0000_3002, 32'h0000_BEEF);
    @(negedge clk_i);
    Req_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (BusReq_o !== 1'b1 || BusAddr_o !== 32'h0000_3000 || BusBe_o !== 4'b1100 ||
                    BusWData_o !== 32'hBEEF_0000 || BusWe_o !== 1'b1 || Done_o !== 1'b0) begin
        errors++;
        $display("FAIL sh_stable cyc%0d: got req %b addr %h be %b wd %h we %b done %b want 1 00003000 1100 beef0000 1 0",
                 i, BusReq_o, BusAddr_o, BusBe_o, BusWData_o, BusWe_o, Done_o);
      end
      if (i == 4) BusGnt_i = 1'b1;
      @(negedge clk_i);
    end
    BusGnt_i = 1'b0;
    checks++; if (Done_o !== 1'b1) begin errors++; $display("FAIL sh_done: got %b want 1", Done_o); end
    checks++; if (ReadData_o !== 32'h0000_0080) begin errors++; $display("FAIL sh_rdata_kept: got %h want 00000080", ReadData_o); end
    @(negedge clk_i);
  endtask

  task automatic test_misaligned;
`ifdef MISALIGNED_SPLIT_EN
    set_req(1'b0, 2'b00, 1'b0, 32'h0000_4001, 32'h0);
    @(negedge clk_i);  // beat 0 request
    checks++; if (BusAddr_o !== 32'h0000_4000 || BusBe_o !== 4'b1110) begin errors++; $display("FAIL ml_beat0: got %h %b want 00004000 1110", BusAddr_o, BusBe_o); end
    Req_i = 1'b0; BusGnt_i = 1'b1;
    @(negedge clk_i);  // WAIT0
    BusGnt_i = 1'b0; BusRValid_i = 1'b1; BusRData_i = 32'h4433_2211;
    @(negedge clk_i);  // beat 1 request
    BusRValid_i = 1'b0;
    checks++; if (BusReq_o !== 1'b1 || BusAddr_o !== 32'h0000_4004 || BusBe_o !== 4'b0001) begin errors++; $display("FAIL ml_beat1: got %b %h %b want 1 00004004 0001", BusReq_o, BusAddr_o, BusBe_o); end
    BusGnt_i = 1'b1;
    @(negedge clk_i);  // WAIT1
    BusGnt_i = 1'b0; BusRValid_i = 1'b1; BusRData_i = 32'h8877_6655;
    @(negedge clk_i);  // DONE
    BusRValid_i = 1'b0;
    checks++; if (Done_o !== 1'b1 || Misaligned_o !== 1'b0) begin errors++; $display("FAIL ml_done: got done %b mis %b want 1 0", Done_o, Misaligned_o); end
    checks++; if (ReadData_o !== 32'h5544_3322) begin errors++; $display("FAIL ml_rdata: got %h want 55443322", ReadData_o); end
    @(negedge clk_i);
    set_req(1'b1, 2'b00, 1'b0, 32'h0000_4003, 32'hAABB_CCDD);
    @(negedge clk_i);
    checks++; if (BusBe_o !== 4'b1000 || BusWData_o !== 32'hDD00_0000) begin errors++; $display("FAIL ms_beat0: got %b %h want 1000 dd000000", BusBe_o, BusWData_o); end
    Req_i = 1'b0; BusGnt_i = 1'b1;
    @(negedge clk_i);
    checks++; if (BusAddr_o !== 32'h0000_4004 || BusBe_o !== 4'b0111 || BusWData_o !== 32'h00AA_BBCC) begin errors++; $display("FAIL ms_beat1: got %h %b %h want 00004004 0111 00aabbcc", BusAddr_o, BusBe_o, BusWData_o); end
    @(negedge clk_i);
    BusGnt_i = 1'b0;
    checks++; if (Done_o !== 1'b1) begin errors++; $display("FAIL ms_done: got %b want 1", Done_o); end
    @(negedge clk_i);
`else
    set_req(1'b0, 2'b00, 1'b0, 32'h0000_4001, 32'h0);
    #1;
    checks++; if (BusReq_o !== 1'b0) begin errors++; $display("FAIL ml_noreq_c0: got %b want 0", BusReq_o); end
    @(negedge clk_i);  // cycle 1
    checks++; if (Done_o !== 1'b1 || Misaligned_o !== 1'b1) begin errors++; $display("FAIL ml_reject: got done %b mis %b want 1 1", Done_o, Misaligned_o); end
    checks++; if (BusReq_o !== 1'b0 || Busy_o !== 1'b0) begin errors++; $display("FAIL ml_nobus: got req %b busy %b want 0 0", BusReq_o, Busy_o); end
    checks++; if (ReadData_o !== 32'h0) begin errors++; $display("FAIL ml_rdata: got %h want 0", ReadData_o); end
    Req_i = 1'b0;
    @(negedge clk_i);
    checks++; if (Done_o !== 1'b0 || Misaligned_o !== 1'b0) begin errors++; $display("FAIL ml_pulse: got done %b mis %b want 0 0", Done_o, Misaligned_o); end
`endif
  endtask

  task automatic test_back_to_back;
    set_req(1'b1, 2'b00, 1'b0, 32'h0000_5000, 32'h1234_5678);
    @(negedge clk_i);  // cycle 1
    checks++; if (BusAddr_o !== 32'h0000_5000 || BusBe_o !== 4'b1111 || BusWData_o !== 32'h1234_5678) begin errors++; $display("FAIL bb_store: got %h %b %h want 00005000 1111 12345678", BusAddr_o, BusBe_o, BusWData_o); end
    Req_i = 1'b0; BusGnt_i = 1'b1;
    @(negedge clk_i);  // DONE: the new request raised here must be ignored
    BusGnt_i = 1'b0;
    checks++; if (Done_o !== 1'b1) begin errors++; $display("FAIL bb_done: got %b want 1", Done_o); end
    set_req(1'b0, 2'b10, 1'b0, 32'h0000_6002, 32'h0);
    @(negedge clk_i);  // IDLE with Req_i high
    checks++; if (BusReq_o !== 1'b0 || Busy_o !== 1'b1 || Done_o !== 1'b0) begin errors++; $display("FAIL bb_idle: got req %b busy %b done %b want 0 1 0", BusReq_o, Busy_o, Done_o); end
    @(negedge clk_i);  // REQ0 for the load
    checks++; if (BusReq_o !== 1'b1 || BusAddr_o !== 32'h0000_6000 || BusBe_o !== 4'b1100 || BusWe_o !== 1'b0) begin errors++; $display("FAIL bb_load_req: got %b %h %b %b want 1 00006000 1100 0", BusReq_o, BusAddr_o, BusBe_o, BusWe_o); end
    Req_i = 1'b0; BusGnt_i = 1'b1;
    @(negedge clk_i);
    BusGnt_i = 1'b0; BusRValid_i = 1'b1; BusRData_i = 32'h8001_0000;
    @(negedge clk_i);
    BusRValid_i = 1'b0;
    checks++; if (Done_o !== 1'b1 || ReadData_o !== 32'hFFFF_8001) begin errors++; $display("FAIL bb_load: got done %b data %h want 1 ffff8001", Done_o, ReadData_o); end
    @(negedge clk_i);
  endtask

  task automatic test_reset_mid;
    set_req(1'b0, 2'b11, 1'b0, 32'h0000_7000, 32'h0);
    @(negedge clk_i);
    checks++; if (BusBe_o !== 4'b1111 || BusAddr_o !== 32'h0000_7000) begin errors++; $display("FAIL rm_type11: got %b %h want 1111 00007000", BusBe_o, BusAddr_o); end
    Req_i = 1'b0; BusGnt_i = 1'b1;
    @(negedge clk_i);  // WAIT0
    BusGnt_i = 1'b0; rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    checks++; if ({ReadData_o, Done_o, Busy_o, Misaligned_o, BusReq_o, BusAddr_o, BusWe_o, BusBe_o, BusWData_o} !== 105'h0) begin
      errors++; $display("FAIL rm_outputs: got rdata %h done %b busy %b req %b addr %h want all 0", ReadData_o, Done_o, Busy_o, BusReq_o, BusAddr_o);
    end
    BusRValid_i = 1'b1; BusRData_i = 32'hDEAD_BEEF;
    @(negedge clk_i);
    BusRValid_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++; if ({ReadData_o, Done_o, Busy_o, Misaligned_o, BusReq_o, BusAddr_o, BusWe_o, BusBe_o, BusWData_o} !== 105'h0) begin
        errors++; $display("FAIL rm_stale cyc%0d: got rdata %h done %b busy %b req %b want all 0", i, ReadData_o, Done_o, Busy_o, BusReq_o);
      end
      @(negedge clk_i);
    end
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_load_byte(1'b0, 32'hFFFF_FF80);
    test_load_byte(1'b1, 32'h0000_0080);
    test_store_half_stall();
    test_misaligned();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/loadstore_unit.md
# loadstore_unit

Multi-cycle data-memory access unit consuming the decoder's memory-control fields (MemWrite, MemType, MemSign). It converts each byte, half or word load/store into word-aligned bus transactions with byte enables, and sign/zero-extends load data. It stalls the core via Busy_o until the access completes. It sits between the datapath (ALU result as address, rs2 as store data) and the data memory port.

## Interface
- DATA_WIDTH, 32, data and bus word width (fixed at 32 for this design)
- ADDR_WIDTH, 32, byte address width
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- Req_i  in  1  load/store request; operands stable while Busy_o high
- MemWrite_i  in  1  1 = store, 0 = load
- MemType_i  in  2  00 word, 01 byte, 10 half, 11 treated as word
- MemSign_i  in  1  loads only: 0 sign-extend, 1 zero-extend
- Addr_i  in  ADDR_WIDTH  byte address
- WriteData_i  in  DATA_WIDTH  store data, right-justified
- ReadData_o  out  DATA_WIDTH  extended load result
- Done_o  out  1  one-cycle completion pulse
- Busy_o  out  1  stall request to core
- Misaligned_o  out  1  pulses with Done_o on a rejected misaligned access
- BusReq_o  out  1  bus request valid
- BusGnt_i  in  1  bus accepts the request this cycle
- BusAddr_o  out  ADDR_WIDTH  word-aligned address, bits [1:0] = 0
- BusWe_o  out  1  write strobe
- BusBe_o  out  4  byte enables
- BusWData_o  out  DATA_WIDTH  lane-shifted store data
- BusRValid_i  in  1  read response valid
- BusRData_i  in  DATA_WIDTH  read response word

## Operation
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE.
- IDLE: when Req_i=1, latch all operands, offset k=Addr_i[1:0], size (1/2/4 bytes); go to REQ0. A split access (k+size>4) without the macro goes to DONE instead.
- REQ0/REQ1: BusReq_o=1 and bus fields held until BusGnt_i. On grant, a write goes to REQ1 (if split and in REQ0) or DONE; a read goes to WAIT0/WAIT1.
- WAIT0/WAIT1: capture BusRData_i on BusRValid_i; go to REQ1 (if split and in WAIT0) or DONE. BusRValid_i is ignored in all other states.
- DONE: Done_o=1 and ReadData_o updated; always returns to IDLE. Req_i is ignored in DONE.
- Busy_o = (state in REQ0..WAIT1) or (state==IDLE and Req_i); it is low in DONE.
- Beat 0: address {Addr[31:2],00}, BusBe_o = (size mask << k)[3:0], BusWData_o = wd << 8k.
- Beat 1: address beat0+4, wrapping mod 2^ADDR_WIDTH; BusBe_o = size mask >> (4-k); BusWData_o = wd >> (32-8k).
- Load assembly: ({r1,r0} >> 8k) truncated to size, then sign- or zero-extended per MemSign_i.
- BusWe_o = latched MemWrite_i during REQ states, 0 otherwise.
- ReadData_o holds its last value until the next load's DONE. Stores leave it unchanged.

## Timing
- Reset: state IDLE. All outputs 0: ReadData_o, Done_o, Busy_o, Misaligned_o, BusReq_o, BusAddr_o, BusWe_o, BusBe_o, BusWData_o.
- Aligned store with immediate grant: Req_i seen in cycle 0, BusReq_o in cycle 1, Done_o in cycle 2.
- Aligned load: Done_o is the cycle after BusRValid_i. Minimum latency is 3 cycles.
- Split access adds 1 cycle for a store, or 1 cycle plus response latency for a load.
- Bus fields are stable while BusReq_o=1 and BusGnt_i=0.
- Reset mid-operation: IDLE on the next edge and BusReq_o drops. Stale responses are ignored and no Done_o is issued.
- A new request can be accepted in the IDLE cycle directly after DONE.

## Configuration
- MISALIGNED_SPLIT_EN defined: split accesses are performed as two beats, and Misaligned_o is constant 0.
- MISALIGNED_SPLIT_EN undefined: a split access issues no bus request and goes IDLE→DONE. Done_o=1, Misaligned_o=1, and ReadData_o=0 for loads. Aligned accesses are unaffected.

## Structure
- Shared package: memtype enum (MEM_WORD=2'b00, MEM_BYTE=2'b01, MEM_HALF=2'b10), lsu state enum, and byte-enable masks (4'b0001, 4'b0011, 4'b1111).
- Sub-module lsu_align (combinational) handles store lane shift/BE generation and load extract/extend. The FSM stays in loadstore_unit.

## Test plan
- Store byte 0xA5 to 0x1003, immediate grant → BusAddr_o=0x1000, BusBe_o=4'b1000, BusWData_o=0xA5000000; Done_o in cycle 2.
- Load byte at 0x2001, MemSign_i=0, response 0x0000_8000 after 3 cycles → ReadData_o=0xFFFFFF80. Same access with MemSign_i=1 → 0x00000080.
- Store half 0xBEEF at 0x3002 with BusGnt_i low for 4 cycles → bus fields stable throughout; BusBe_o=4'b1100, BusWData_o=0xBEEF0000.
- With macro: load word at 0x4001, responses 0x44332211 then 0x88776655 → two beats at 0x4000/0x4004, ReadData_o=0x55443322.
- Without macro: same word load → no BusReq_o; Done_o and Misaligned_o in cycle 1; ReadData_o=0.
- rst_i asserted while in WAIT0, then BusRValid_i pulses → state IDLE; no Done_o; all outputs 0.
